ex_alu_ctrl_pipe: RTL and testbench

- Next-generation ALU control for the five-stage MIPS core.
- Decodes the ID-stage instruction into a wider ALU opcode and operand type, and registers the result into the EX stage with stall and flush support.
- Tracks a multi-cycle mult/div unit and raises a hazard stall request for dependent HI/LO instructions.
- Sits between the ID/EX pipeline register and the ALU / mult-div datapath.

---
 rtl/ex_alu_ctrl_if.sv | 26 ++
 rtl/ex_alu_ctrl_pipe.sv | 109 ++++++++++
 tb/tb_ex_alu_ctrl_pipe.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/ex_alu_ctrl_if.sv
// ID/EX control bundle between the pipeline and the EX ALU control block.
// The master side is the pipeline; the slave side is ex_alu_ctrl_pipe.
interface ex_alu_ctrl_if #(
  parameter int OP_W = 4
);
  logic [31:0]     id_ins;
  logic            stall;
  logic            flush;
  logic [OP_W-1:0] alu_op;
  logic            alu_type;
  logic            illegal;
  logic            md_start;
  logic            md_is_div;
  logic            md_busy;
  logic            stall_req;

  modport master (
    output id_ins, stall, flush,
    input  alu_op, alu_type, illegal, md_start, md_is_div, md_busy, stall_req
  );

  modport slave (
    input  id_ins, stall, flush,
    output alu_op, alu_type, illegal, md_start, md_is_div, md_busy, stall_req
  );
endinterface

// File: rtl/ex_alu_ctrl_pipe.sv
// EX-stage ALU control: decodes the ID instruction into a registered ALU op,
// and tracks the multi-cycle mult/div unit so dependent HI/LO reads stall ID.
module ex_alu_ctrl_pipe #(
  parameter int OP_W        = 4,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  ex_alu_ctrl_if.slave bus
);

  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(3'd0);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(3'd1);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(3'd2);
  localparam logic [OP_W-1:0] OP_LUI  = OP_W'(3'd3);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(3'd4);
  localparam logic [OP_W-1:0] OP_SLT  = OP_W'(3'd5);
  localparam logic [OP_W-1:0] OP_SLTU = OP_W'(3'd6);
  localparam logic [OP_W-1:0] OP_SLL  = OP_W'(3'd7);

  typedef struct packed {
    logic [OP_W-1:0] op;
    logic            ty;
    logic            ill;
  } ex_ctrl_t;

  ex_ctrl_t         dec, ex_q;
  logic [5:0]       opc, fn;
  logic             id_md, id_div, id_hilo, md_load;
  logic             md_start_q, md_is_div_q;
  logic [CNT_W-1:0] cnt_q;

  assign opc     = bus.id_ins[31:26];
  assign fn      = bus.id_ins[5:0];
  // funct 0x18..0x1B: mult, multu, div, divu; bit 1 selects the divides
  assign id_md   = (opc == 6'h00) && (fn[5:2] == 4'b0110);
  assign id_div  = id_md && fn[1];
  assign id_hilo = (opc == 6'h00) && ((fn == 6'h10) || (fn == 6'h12));
  assign md_load = !bus.flush && !bus.stall && id_md;

  always_comb begin
    dec = '0;
    // all-zero word is the canonical NOP, not sll
    if (bus.id_ins != 32'h0) begin
      if (opc == 6'h00) begin
        case (fn)
          6'h21:   dec.op = OP_ADD;
          6'h23:   dec.op = OP_SUB;
          6'h24:   dec.op = OP_AND;
          6'h25:   dec.op = OP_OR;
          6'h2A:   dec.op = OP_SLT;
          6'h2B:   dec.op = OP_SLTU;
          6'h00:   dec.op = OP_SLL;
          6'h10, 6'h12, 6'h18, 6'h19, 6'h1A, 6'h1B: dec.op = OP_ADD;
          default: dec.ill = 1'b1;
        endcase
      end else begin
        dec.ty = 1'b1;
        case (opc)
          6'h0D:               dec.op = OP_OR;
          6'h0F:               dec.op = OP_LUI;
          6'h23, 6'h2B, 6'h09: dec.op = OP_ADD;
          6'h0C:               dec.op = OP_AND;
          default: begin
            dec.ty  = 1'b0;
            dec.ill = 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ex_q        <= '0;
      md_start_q  <= 1'b0;
      md_is_div_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      if (bus.flush) begin
        ex_q       <= '0;
        md_start_q <= 1'b0;
      end else if (bus.stall) begin
        md_start_q <= 1'b0;
      end else begin
        ex_q       <= dec;
        md_start_q <= id_md;
      end
      // a flush never cancels an in-flight op; the unit keeps counting down
      if (md_load) begin
        cnt_q       <= id_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        md_is_div_q <= id_div;
      end else if (cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  assign bus.alu_op    = ex_q.op;
  assign bus.alu_type  = ex_q.ty;
  assign bus.illegal   = ex_q.ill;
  assign bus.md_start  = md_start_q;
  assign bus.md_is_div = md_is_div_q;
  assign bus.md_busy   = (cnt_q != '0);
  assign bus.stall_req = (bus.md_busy | md_start_q) & (id_md | id_hilo);

endmodule

// File: tb/tb_ex_alu_ctrl_pipe.sv
// Directed plus randomized bench for ex_alu_ctrl_pipe against a cycle-level
// behavioural model of the EX control register and the mult/div busy window.
module tb_ex_alu_ctrl_pipe;

  localparam int MULT_C = 5;
  localparam int DIV_C  = 10;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  ex_alu_ctrl_if #(.OP_W(4)) bus ();

  ex_alu_ctrl_pipe #(
    .OP_W(4), .MULT_CYCLES(MULT_C), .DIV_CYCLES(DIV_C), .CNT_W(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  int m_op, m_left;
  bit m_ty, m_ill, m_start, m_isdiv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_dec(input logic [31:0] i, output int op, output bit ty, output bit ill);
    op = 0; ty = 0; ill = 0;
    if (i == 32'h0) return;
    if (i[31:26] == 6'h00) begin
      case (i[5:0])
        6'h21: op = 0;
        6'h23: op = 1;
        6'h24: op = 4;
        6'h25: op = 2;
        6'h2A: op = 5;
        6'h2B: op = 6;
        6'h00: op = 7;
        6'h10, 6'h12, 6'h18, 6'h19, 6'h1A, 6'h1B: op = 0;
        default: ill = 1;
      endcase
    end else begin
      case (i[31:26])
        6'h0D: begin op = 2; ty = 1; end
        6'h0F: begin op = 3; ty = 1; end
        6'h23, 6'h2B, 6'h09: begin op = 0; ty = 1; end
        6'h0C: begin op = 4; ty = 1; end
        default: ill = 1;
      endcase
    end
  endfunction

  function automatic bit is_md(input logic [31:0] i);
    return (i[31:26] == 6'h00) && (i[5:0] inside {6'h18, 6'h19, 6'h1A, 6'h1B});
  endfunction

  function automatic bit is_divop(input logic [31:0] i);
    return is_md(i) && (i[5:0] inside {6'h1A, 6'h1B});
  endfunction

  function automatic bit is_hilo(input logic [31:0] i);
    return (i[31:26] == 6'h00) && (i[5:0] inside {6'h10, 6'h12});
  endfunction

  // apply new ID-side inputs, let them settle, and check the combinational request
  task automatic drive(input logic rn, input logic [31:0] ins, input logic st, input logic fl);
    bit exp_req;
    reset_n = rn; bus.id_ins = ins; bus.stall = st; bus.flush = fl;
    #1;
    exp_req = ((m_left > 0) || m_start) && (is_md(ins) || is_hilo(ins));
    chk("stall_req", 32'(bus.stall_req), 32'(exp_req));
  endtask

  // one rising edge; advance the model with the inputs that edge sampled
  task automatic tick();
    logic        rn, st, fl;
    logic [31:0] ins;
    int op; bit ty, ill;
    rn = reset_n; ins = bus.id_ins; st = bus.stall; fl = bus.flush;
    @(posedge clk);
    #1;
    if (!rn) begin
      m_op = 0; m_ty = 0; m_ill = 0; m_start = 0; m_isdiv = 0; m_left = 0;
    end else begin
      if (m_left > 0) m_left--;
      if (fl) begin
        m_op = 0; m_ty = 0; m_ill = 0; m_start = 0;
      end else if (st) begin
        m_start = 0;
      end else begin
        ref_dec(ins, op, ty, ill);
        m_op = op; m_ty = ty; m_ill = ill; m_start = is_md(ins);
        if (m_start) begin
          m_isdiv = is_divop(ins);
          m_left  = m_isdiv ? DIV_C : MULT_C;
        end
      end
    end
    chk("alu_op",    32'(bus.alu_op),    32'(m_op));
    chk("alu_type",  32'(bus.alu_type),  32'(m_ty));
    chk("illegal",   32'(bus.illegal),   32'(m_ill));
    chk("md_start",  32'(bus.md_start),  32'(m_start));
    chk("md_is_div", 32'(bus.md_is_div), 32'(m_isdiv));
    chk("md_busy",   32'(bus.md_busy),   32'(m_left > 0));
  endtask

  typedef struct {
    logic [31:0] ins;
    int          op;
    bit          ty;
    bit          ill;
  } vec_t;

  localparam logic [31:0] I_ADDU = 32'h00221821;
  localparam logic [31:0] I_SUBU = 32'h00221823;
  localparam logic [31:0] I_ORI  = 32'h34210001;
  localparam logic [31:0] I_MULT = 32'h00220018;
  localparam logic [31:0] I_DIV  = 32'h0022001A;
  localparam logic [31:0] I_MFLO = 32'h00001812;

  initial begin
    vec_t sweep[6];
    logic [31:0] pool[16];
    logic [31:0] r;
    int n;
    m_op = 0; m_ty = 0; m_ill = 0; m_start = 0; m_isdiv = 0; m_left = 0;

    // reset held for two edges
    drive(1'b0, I_ADDU, 1'b0, 1'b0);
    tick(); tick();
    chk("rst_alu_op", 32'(bus.alu_op), 32'd0);
    chk("rst_busy", 32'(bus.md_busy), 32'd0);
    drive(1'b1, I_ADDU, 1'b0, 1'b0);
    tick();
    chk("addu_op", 32'(bus.alu_op), 32'd0);
    chk("addu_type", 32'(bus.alu_type), 32'd0);

    // decode sweep
    sweep[0] = '{I_SUBU,       1, 0, 0};
    sweep[1] = '{I_ORI,        2, 1, 0};
    sweep[2] = '{32'h3C011234, 3, 1, 0};
    sweep[3] = '{32'h8C220004, 0, 1, 0};
    sweep[4] = '{32'h0022182A, 5, 0, 0};
    sweep[5] = '{32'hFC000000, 0, 0, 1};
    foreach (sweep[k]) begin
      drive(1'b1, sweep[k].ins, 1'b0, 1'b0);
      tick();
      chk($sformatf("sweep%0d_op", k),  32'(bus.alu_op),   32'(sweep[k].op));
      chk($sformatf("sweep%0d_ty", k),  32'(bus.alu_type), 32'(sweep[k].ty));
      chk($sformatf("sweep%0d_ill", k), 32'(bus.illegal),  32'(sweep[k].ill));
    end

    // stall holds EX, flush wins over stall
    drive(1'b1, I_ORI, 1'b0, 1'b0);  tick();
    drive(1'b1, I_SUBU, 1'b1, 1'b0); tick();
    chk("stall_hold_op", 32'(bus.alu_op), 32'd2);
    drive(1'b1, I_SUBU, 1'b1, 1'b1); tick();
    chk("flush_op", 32'(bus.alu_op), 32'd0);
    chk("flush_ty", 32'(bus.alu_type), 32'd0);

    // multiply busy window
    drive(1'b1, I_MULT, 1'b0, 1'b0); tick();
    chk("mult_start", 32'(bus.md_start), 32'd1);
    n = 0;
    drive(1'b1, 32'h0, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      if (bus.md_busy) n++;
      tick();
    end
    chk("mult_busy_cycles", 32'(n), 32'(MULT_C));
    chk("mult_is_div", 32'(bus.md_is_div), 32'd0);

    // divide followed by dependent mflo; stall fed back from stall_req
    drive(1'b1, I_DIV, 1'b0, 1'b0); tick();
    drive(1'b1, I_MFLO, 1'b0, 1'b0);
    n = 0;
    while (bus.stall_req && n < 30) begin
      drive(1'b1, I_MFLO, 1'b1, 1'b0);
      tick();
      n++;
      drive(1'b1, I_MFLO, 1'b0, 1'b0);
    end
    chk("div_stall_cycles", 32'(n), 32'(DIV_C));
    tick();
    chk("mflo_in_ex_ill", 32'(bus.illegal), 32'd0);
    chk("mflo_is_div", 32'(bus.md_is_div), 32'd1);
    chk("mflo_busy", 32'(bus.md_busy), 32'd0);

    // reset in the middle of a divide
    drive(1'b1, I_DIV, 1'b0, 1'b0); tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, I_MFLO, 1'b1, 1'b0); tick();
    end
    chk("mid_div_busy", 32'(bus.md_busy), 32'd1);
    drive(1'b0, I_MFLO, 1'b1, 1'b0); tick();
    chk("rst_mid_busy", 32'(bus.md_busy), 32'd0);
    drive(1'b1, I_MFLO, 1'b0, 1'b0);
    chk("rst_mid_req", 32'(bus.stall_req), 32'd0);
    tick();

    // randomized traffic with pipeline stall feedback
    pool = '{I_ADDU, I_SUBU, 32'h00221824, 32'h00221825, 32'h0022182A, 32'h0022182B,
             32'h00011080, I_ORI, 32'h3C01ABCD, 32'h8C220004, 32'hAC220004, 32'h24210010,
             32'h3021FFFF, I_MULT, I_DIV, I_MFLO};
    for (int c = 0; c < 500; c++) begin
      case ($urandom_range(0, 9))
        0:       r = $urandom;
        1:       r = 32'h0;
        2:       r = {6'h00, 20'($urandom), 6'h10 | 6'($urandom_range(0, 11))};
        default: r = pool[$urandom_range(0, 15)];
      endcase
      drive(($urandom_range(0, 59) != 0), r, 1'b0, 1'b0);
      drive(reset_n, r, bus.stall_req | ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 11) == 0));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
